// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b one bit per cycle, LSB first, one full-subtractor cell.
// Latency: out_valid rises WIDTH cycles after the accept edge; accepts are spaced at least WIDTH+2 cycles apart.
// Backpressure: the result is held in DONE until out_ready; in_ready is low everywhere except IDLE.
module serial_subtractor #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             busy
);

    // One extra bit so the counter can reach WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_q;
    logic [WIDTH-1:0] diff_nxt;
    logic             br;
    logic             br_nxt;
    logic             d;
    logic [CW-1:0]    cnt;
    logic             last_bit;

    // Status outputs decode the registered state only.
    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign last_bit  = (cnt == LAST);

    // Full-subtractor cell on the current LSBs; the new difference bit enters at the top of diff_q.
    always_comb begin
        d        = a_sh[0] ^ b_sh[0] ^ br;
        br_nxt   = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        diff_nxt = (diff_q >> 1) | (WIDTH'(d) << (WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: no bypass from DONE straight to a new accept.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = BUSY;
            BUSY:    if (last_bit)  state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, shift one bit per BUSY cycle, load out on the last bit only.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_sh   <= '0;
            b_sh   <= '0;
            diff_q <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        diff_q <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    diff_q <= diff_nxt;
                    br     <= br_nxt;
                    cnt    <= cnt + CW'(1);
                    if (last_bit) begin
                        out <= {br_nxt, diff_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clock;
    int         n_cmp;
    int         n_bad;

    // WIDTH=2 instance
    logic       r2, iv2, ir2, ov2, ordy2, bz2;
    logic [1:0] a2, b2;
    logic [2:0] o2;

    // WIDTH=8 instance
    logic       r8, iv8, ir8, ov8, ordy8, bz8;
    logic [7:0] a8, b8;
    logic [8:0] o8;

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clock(clock), .reset(r2), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .out_valid(ov2), .out_ready(ordy2), .out(o2), .busy(bz2)
    );

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(r8), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .out_valid(ov8), .out_ready(ordy8), .out(o8), .busy(bz8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Submit one operation to the WIDTH=2 instance; lat counts cycles after the accept edge until out_valid.
    task automatic run2(input logic [1:0] av, input logic [1:0] bv, output logic [2:0] res, output int lat);
        a2 = av; b2 = bv; iv2 = 1'b1; ordy2 = 1'b1;
        tick;
        iv2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 20) begin
            tick;
            lat++;
        end
        res = o2;
    endtask

    task automatic run8(input logic [7:0] av, input logic [7:0] bv, output logic [8:0] res, output int lat);
        a8 = av; b8 = bv; iv8 = 1'b1; ordy8 = 1'b1;
        tick;
        iv8 = 1'b0;
        lat = 0;
        while (!ov8 && lat < 40) begin
            tick;
            lat++;
        end
        res = o8;
    endtask

    task automatic test_reset;
        r2 = 1'b1; r8 = 1'b1;
        iv2 = 1'b0; iv8 = 1'b0; ordy2 = 1'b0; ordy8 = 1'b0;
        a2 = '0; b2 = '0; a8 = '0; b8 = '0;
        #1;
        n_cmp++; if (ir2 !== 1'b1)  begin n_bad++; $display("FAIL reset_ir2: got %b expected 1", ir2); end
        n_cmp++; if (ov2 !== 1'b0)  begin n_bad++; $display("FAIL reset_ov2: got %b expected 0", ov2); end
        n_cmp++; if (bz2 !== 1'b0)  begin n_bad++; $display("FAIL reset_bz2: got %b expected 0", bz2); end
        n_cmp++; if (o2 !== 3'b000) begin n_bad++; $display("FAIL reset_o2: got %b expected 000", o2); end
        n_cmp++; if (ir8 !== 1'b1)  begin n_bad++; $display("FAIL reset_ir8: got %b expected 1", ir8); end
        n_cmp++; if (ov8 !== 1'b0)  begin n_bad++; $display("FAIL reset_ov8: got %b expected 0", ov8); end
        n_cmp++; if (bz8 !== 1'b0)  begin n_bad++; $display("FAIL reset_bz8: got %b expected 0", bz8); end
        n_cmp++; if (o8 !== 9'h000) begin n_bad++; $display("FAIL reset_o8: got %h expected 000", o8); end
        // in_valid during reset must not start anything
        iv2 = 1'b1;
        tick;
        tick;
        n_cmp++; if (bz2 !== 1'b0)  begin n_bad++; $display("FAIL reset_hold_bz2: got %b expected 0", bz2); end
        iv2 = 1'b0;
        r2 = 1'b0; r8 = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        logic [2:0] res;
        int         lat;
        a2 = 2'd3; b2 = 2'd1; iv2 = 1'b1; ordy2 = 1'b1;
        tick;
        iv2 = 1'b0;
        n_cmp++; if (bz2 !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b expected 1", bz2); end
        n_cmp++; if (ir2 !== 1'b0) begin n_bad++; $display("FAIL basic_in_ready_busy: got %b expected 0", ir2); end
        lat = 0;
        while (!ov2 && lat < 20) begin
            tick;
            lat++;
        end
        res = o2;
        n_cmp++; if (lat !== 2)       begin n_bad++; $display("FAIL basic_latency: got %0d expected 2", lat); end
        n_cmp++; if (res !== 3'b010)  begin n_bad++; $display("FAIL basic_out: got %b expected 010", res); end
        n_cmp++; if (bz2 !== 1'b0)    begin n_bad++; $display("FAIL basic_busy_done: got %b expected 0", bz2); end
        tick;
        n_cmp++; if (ir2 !== 1'b1)    begin n_bad++; $display("FAIL basic_idle_again: got %b expected 1", ir2); end
        n_cmp++; if (ov2 !== 1'b0)    begin n_bad++; $display("FAIL basic_ov_drop: got %b expected 0", ov2); end
        n_cmp++; if (o2 !== 3'b010)   begin n_bad++; $display("FAIL basic_out_retained: got %b expected 010", o2); end
    endtask

    task automatic test_arith;
        logic [2:0] res;
        int         lat;
        run2(2'd1, 2'd2, res, lat);
        n_cmp++; if (res !== 3'b111) begin n_bad++; $display("FAIL arith_1m2: got %b expected 111", res); end
        n_cmp++; if (lat !== 2)      begin n_bad++; $display("FAIL arith_1m2_lat: got %0d expected 2", lat); end
        tick;
        run2(2'd0, 2'd0, res, lat);
        n_cmp++; if (res !== 3'b000) begin n_bad++; $display("FAIL arith_0m0: got %b expected 000", res); end
        tick;
        run2(2'd2, 2'd1, res, lat);
        n_cmp++; if (res !== 3'b001) begin n_bad++; $display("FAIL arith_2m1: got %b expected 001", res); end
        tick;
    endtask

    task automatic test_backpressure;
        int wait_cyc;
        a2 = 2'd2; b2 = 2'd3; iv2 = 1'b1; ordy2 = 1'b0;
        tick;
        iv2 = 1'b0;
        // operand changes while BUSY must not disturb the captured values
        a2 = 2'd3; b2 = 2'd0;
        wait_cyc = 0;
        while (!ov2 && wait_cyc < 20) begin
            tick;
            wait_cyc++;
        end
        n_cmp++; if (ov2 !== 1'b1)   begin n_bad++; $display("FAIL bp_reach_done: got %b expected 1", ov2); end
        n_cmp++; if (o2 !== 3'b111)  begin n_bad++; $display("FAIL bp_out: got %b expected 111", o2); end
        for (int i = 0; i < 5; i++) begin
            iv2 = i[0];
            a2 = 2'(i); b2 = 2'(i + 1);
            tick;
            n_cmp++; if (ov2 !== 1'b1)  begin n_bad++; $display("FAIL bp_hold_ov[%0d]: got %b expected 1", i, ov2); end
            n_cmp++; if (o2 !== 3'b111) begin n_bad++; $display("FAIL bp_hold_out[%0d]: got %b expected 111", i, o2); end
            n_cmp++; if (ir2 !== 1'b0)  begin n_bad++; $display("FAIL bp_hold_ir[%0d]: got %b expected 0", i, ir2); end
        end
        iv2 = 1'b0;
        ordy2 = 1'b1;
        tick;
        n_cmp++; if (ir2 !== 1'b1)   begin n_bad++; $display("FAIL bp_release_ir: got %b expected 1", ir2); end
        n_cmp++; if (ov2 !== 1'b0)   begin n_bad++; $display("FAIL bp_release_ov: got %b expected 0", ov2); end
        // out_ready held high in IDLE has no effect
        tick;
        n_cmp++; if (o2 !== 3'b111)  begin n_bad++; $display("FAIL bp_idle_out: got %b expected 111", o2); end
        n_cmp++; if (ir2 !== 1'b1)   begin n_bad++; $display("FAIL bp_idle_ir: got %b expected 1", ir2); end
    endtask

    task automatic test_reset_midop;
        logic [8:0] res;
        int         lat;
        a8 = 8'd200; b8 = 8'd55; iv8 = 1'b1; ordy8 = 1'b1;
        tick;
        iv8 = 1'b0;
        tick; tick; tick;
        n_cmp++; if (bz8 !== 1'b1)   begin n_bad++; $display("FAIL midop_busy: got %b expected 1", bz8); end
        r8 = 1'b1;
        #1;
        n_cmp++; if (ir8 !== 1'b1)   begin n_bad++; $display("FAIL midop_ir: got %b expected 1", ir8); end
        n_cmp++; if (ov8 !== 1'b0)   begin n_bad++; $display("FAIL midop_ov: got %b expected 0", ov8); end
        n_cmp++; if (bz8 !== 1'b0)   begin n_bad++; $display("FAIL midop_bz: got %b expected 0", bz8); end
        n_cmp++; if (o8 !== 9'h000)  begin n_bad++; $display("FAIL midop_out: got %h expected 000", o8); end
        tick;
        r8 = 1'b0;
        run8(8'd200, 8'd55, res, lat);
        n_cmp++; if (res !== 9'h091) begin n_bad++; $display("FAIL midop_resubmit: got %h expected 091", res); end
        n_cmp++; if (lat !== 8)      begin n_bad++; $display("FAIL midop_latency: got %0d expected 8", lat); end
        tick;
    endtask

    task automatic test_back_to_back;
        logic [7:0] pa [3];
        logic [7:0] pb [3];
        logic [8:0] exp_res [3];
        logic [8:0] got [3];
        int         acc [3];
        int         k;
        int         nres;
        logic       acc_now;
        pa = '{8'd255, 8'd0, 8'd128};
        pb = '{8'd0, 8'd255, 8'd128};
        exp_res = '{9'h0FF, 9'h101, 9'h000};
        got = '{9'hxxx, 9'hxxx, 9'hxxx};
        acc = '{-100, -100, -100};
        k = 0; nres = 0;
        a8 = pa[0]; b8 = pb[0]; iv8 = 1'b1; ordy8 = 1'b1;
        for (int cyc = 0; cyc < 60 && nres < 3; cyc++) begin
            acc_now = ir8 && iv8;
            tick;
            if (acc_now && k < 3) begin
                acc[k] = cyc;
                k++;
                if (k < 3) begin
                    a8 = pa[k]; b8 = pb[k];
                end else begin
                    iv8 = 1'b0;
                end
            end
            if (ov8 && nres < 3) begin
                got[nres] = o8;
                nres++;
            end
        end
        iv8 = 1'b0;
        tick;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (got[i] !== exp_res[i]) begin
                n_bad++; $display("FAIL b2b_result[%0d]: got %h expected %h", i, got[i], exp_res[i]);
            end
        end
        n_cmp++; if (acc[1] - acc[0] !== 10) begin n_bad++; $display("FAIL b2b_spacing01: got %0d expected 10", acc[1] - acc[0]); end
        n_cmp++; if (acc[2] - acc[1] !== 10) begin n_bad++; $display("FAIL b2b_spacing12: got %0d expected 10", acc[2] - acc[1]); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset;
        test_basic;
        test_arith;
        test_backpressure;
        test_reset_midop;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
